// File: rtl/fifo_pkg.sv
// Pointer helpers shared by the write- and read-domain controllers of the asynchronous FIFO.
// Helpers work on a 32-bit container and ignore bits at or above the requested width.
package fifo_pkg;

   localparam int unsigned MAX_PTR_BITS = 32;

   function automatic int unsigned fifo_depth(input int unsigned ptr_width);
      return 32'd1 << ptr_width;
   endfunction

   function automatic logic [MAX_PTR_BITS-1:0] width_mask(input int unsigned width);
      logic [MAX_PTR_BITS-1:0] m;
      if (width >= MAX_PTR_BITS)
         m = '1;
      else
         m = (32'd1 << width) - 32'd1;
      return m;
   endfunction

   function automatic logic [MAX_PTR_BITS-1:0] bin2gray(input logic [MAX_PTR_BITS-1:0] bin,
                                                        input int unsigned width);
      logic [MAX_PTR_BITS-1:0] b;
      b = bin & width_mask(width);
      return b ^ (b >> 1);
   endfunction

   // XOR prefix from the MSB; the masked upper bits are zero so they do not disturb the result.
   function automatic logic [MAX_PTR_BITS-1:0] gray2bin(input logic [MAX_PTR_BITS-1:0] gray,
                                                        input int unsigned width);
      logic [MAX_PTR_BITS-1:0] g;
      logic [MAX_PTR_BITS-1:0] b;
      g = gray & width_mask(width);
      b = '0;
      b[MAX_PTR_BITS-1] = g[MAX_PTR_BITS-1];
      for (int i = MAX_PTR_BITS - 2; i >= 0; i--)
         b[i] = b[i+1] ^ g[i];
      return b;
   endfunction

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchroniser for a Gray-coded pointer crossing into this clock domain.
module sync_chain #(
   parameter int WIDTH  = 1,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [STAGES-1:0][WIDTH-1:0] chain;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         chain <= '0;
      else
         chain <= {chain[STAGES-2:0], d};
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/wptr_ctrl.sv
// Write-domain pointer controller: binary/Gray write pointers plus registered full,
// almost-full, fill level, write acknowledge and sticky overflow.
module wptr_ctrl
   import fifo_pkg::*;
#(
   parameter int PTR_WIDTH   = 6,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 wclk,
   input  logic                 rst,
   input  logic                 w_en,
   input  logic [PTR_WIDTH:0]   g_rptr_async,
   input  logic [PTR_WIDTH:0]   af_thresh,
   input  logic                 clr_ovf,
   output logic [PTR_WIDTH:0]   b_wptr,
   output logic [PTR_WIDTH:0]   g_wptr,
   output logic [PTR_WIDTH-1:0] waddr,
   output logic                 full,
   output logic                 almost_full,
   output logic [PTR_WIDTH:0]   wr_level,
   output logic                 wr_ack,
   output logic                 overflow
);

   localparam int unsigned PW    = PTR_WIDTH + 1;
   localparam int unsigned DEPTH = fifo_depth(PTR_WIDTH);

   logic [PTR_WIDTH:0] g_rptr_s;
   logic [PTR_WIDTH:0] b_rptr_s;
   logic [PTR_WIDTH:0] b_next;
   logic [PTR_WIDTH:0] g_next;
   logic [PTR_WIDTH:0] level_next;
   logic               wr_acc;
   logic               full_next;
   logic               af_next;

   sync_chain #(
      .WIDTH  (PW),
      .STAGES (SYNC_STAGES)
   ) u_rptr_sync (
      .clk   (wclk),
      .rst_n (rst),
      .d     (g_rptr_async),
      .q     (g_rptr_s)
   );

   assign b_rptr_s   = PW'(gray2bin(32'(g_rptr_s), PW));
   assign wr_acc     = w_en & ~full;
   assign b_next     = b_wptr + PW'(wr_acc);
   assign g_next     = PW'(bin2gray(32'(b_next), PW));
   assign level_next = b_next - b_rptr_s;

   // Full when the write pointer is one lap ahead: top two Gray bits inverted, rest equal.
   assign full_next = (g_next == {~g_rptr_s[PTR_WIDTH:PTR_WIDTH-1], g_rptr_s[PTR_WIDTH-2:0]});
   // Level never exceeds DEPTH, so a threshold above DEPTH can never be reached.
   assign af_next   = (af_thresh <= PW'(DEPTH)) && (level_next >= af_thresh);

   assign waddr = b_wptr[PTR_WIDTH-1:0];

   always_ff @(posedge wclk or negedge rst) begin
      if (!rst) begin
         b_wptr      <= '0;
         g_wptr      <= '0;
         full        <= 1'b0;
         almost_full <= 1'b0;
         wr_level    <= '0;
         wr_ack      <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         b_wptr      <= b_next;
         g_wptr      <= g_next;
         full        <= full_next;
         almost_full <= af_next;
         wr_level    <= level_next;
         wr_ack      <= wr_acc;
         overflow    <= (w_en & full) | (overflow & ~clr_ovf);
      end
   end

endmodule

// File: tb/tb_wptr_ctrl.sv
// Directed bench for wptr_ctrl with PTR_WIDTH=3, SYNC_STAGES=2, af_thresh=6.
module tb_wptr_ctrl;

   logic       wclk;
   logic       rst;
   logic       w_en;
   logic [3:0] g_rptr_async;
   logic [3:0] af_thresh;
   logic       clr_ovf;
   logic [3:0] b_wptr;
   logic [3:0] g_wptr;
   logic [2:0] waddr;
   logic       full;
   logic       almost_full;
   logic [3:0] wr_level;
   logic       wr_ack;
   logic       overflow;

   int checks = 0;
   int errors = 0;

   wptr_ctrl #(
      .PTR_WIDTH   (3),
      .SYNC_STAGES (2)
   ) dut (
      .wclk         (wclk),
      .rst          (rst),
      .w_en         (w_en),
      .g_rptr_async (g_rptr_async),
      .af_thresh    (af_thresh),
      .clr_ovf      (clr_ovf),
      .b_wptr       (b_wptr),
      .g_wptr       (g_wptr),
      .waddr        (waddr),
      .full         (full),
      .almost_full  (almost_full),
      .wr_level     (wr_level),
      .wr_ack       (wr_ack),
      .overflow     (overflow)
   );

   initial wclk = 1'b0;
   always #5 wclk = ~wclk;

   typedef struct {
      logic       w_en;
      logic [3:0] g_r;
      logic       clr;
      logic [3:0] b;
      logic [3:0] g;
      logic       full;
      logic       af;
      logic [3:0] lvl;
      logic       ack;
      logic       ovf;
   } vec_t;

   localparam int NVEC = 19;
   vec_t vecs [NVEC];

   function automatic vec_t mk(input logic we, input logic [3:0] gr, input logic clr,
                               input logic [3:0] b, input logic [3:0] g, input logic f,
                               input logic af, input logic [3:0] lvl, input logic ack,
                               input logic ovf);
      vec_t v;
      v.w_en = we; v.g_r = gr; v.clr = clr; v.b = b; v.g = g;
      v.full = f; v.af = af; v.lvl = lvl; v.ack = ack; v.ovf = ovf;
      return v;
   endfunction

   function automatic logic [3:0] gray4(input logic [3:0] v);
      return v ^ (v >> 1);
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_outputs(input string tag, input logic [3:0] b, input logic [3:0] g,
                              input logic f, input logic af, input logic [3:0] lvl,
                              input logic ack, input logic ovf);
      logic [2:0] wa;
      wa = b[2:0];
      chk({tag, ".b_wptr"},      int'(b_wptr),      int'(b));
      chk({tag, ".g_wptr"},      int'(g_wptr),      int'(g));
      chk({tag, ".waddr"},       int'(waddr),       int'(wa));
      chk({tag, ".full"},        int'(full),        int'(f));
      chk({tag, ".almost_full"}, int'(almost_full), int'(af));
      chk({tag, ".wr_level"},    int'(wr_level),    int'(lvl));
      chk({tag, ".wr_ack"},      int'(wr_ack),      int'(ack));
      chk({tag, ".overflow"},    int'(overflow),    int'(ovf));
   endtask

   task automatic tick();
      @(posedge wclk);
      #1;
   endtask

   initial begin
      int         n;
      bit         seen;
      logic [3:0] rp;
      logic [3:0] eb;
      logic [3:0] el;

      // Fill, overflow, drain, then re-settle the read pointer at 7 ahead of the wrap run.
      vecs[0]  = mk(1'b1, 4'b0000, 1'b0, 4'd1, 4'b0001, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0);
      vecs[1]  = mk(1'b1, 4'b0000, 1'b0, 4'd2, 4'b0011, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0);
      vecs[2]  = mk(1'b1, 4'b0000, 1'b0, 4'd3, 4'b0010, 1'b0, 1'b0, 4'd3, 1'b1, 1'b0);
      vecs[3]  = mk(1'b1, 4'b0000, 1'b0, 4'd4, 4'b0110, 1'b0, 1'b0, 4'd4, 1'b1, 1'b0);
      vecs[4]  = mk(1'b1, 4'b0000, 1'b0, 4'd5, 4'b0111, 1'b0, 1'b0, 4'd5, 1'b1, 1'b0);
      vecs[5]  = mk(1'b1, 4'b0000, 1'b0, 4'd6, 4'b0101, 1'b0, 1'b1, 4'd6, 1'b1, 1'b0);
      vecs[6]  = mk(1'b1, 4'b0000, 1'b0, 4'd7, 4'b0100, 1'b0, 1'b1, 4'd7, 1'b1, 1'b0);
      vecs[7]  = mk(1'b1, 4'b0000, 1'b0, 4'd8, 4'b1100, 1'b1, 1'b1, 4'd8, 1'b1, 1'b0);
      vecs[8]  = mk(1'b1, 4'b0000, 1'b0, 4'd8, 4'b1100, 1'b1, 1'b1, 4'd8, 1'b0, 1'b1);
      vecs[9]  = mk(1'b1, 4'b0000, 1'b1, 4'd8, 4'b1100, 1'b1, 1'b1, 4'd8, 1'b0, 1'b1);
      vecs[10] = mk(1'b0, 4'b0000, 1'b1, 4'd8, 4'b1100, 1'b1, 1'b1, 4'd8, 1'b0, 1'b0);
      vecs[11] = mk(1'b0, 4'b0010, 1'b0, 4'd8, 4'b1100, 1'b1, 1'b1, 4'd8, 1'b0, 1'b0);
      vecs[12] = mk(1'b0, 4'b0010, 1'b0, 4'd8, 4'b1100, 1'b1, 1'b1, 4'd8, 1'b0, 1'b0);
      vecs[13] = mk(1'b0, 4'b0010, 1'b0, 4'd8, 4'b1100, 1'b0, 1'b0, 4'd5, 1'b0, 1'b0);
      vecs[14] = mk(1'b0, 4'b0010, 1'b0, 4'd8, 4'b1100, 1'b0, 1'b0, 4'd5, 1'b0, 1'b0);
      vecs[15] = mk(1'b1, 4'b0010, 1'b0, 4'd9, 4'b1101, 1'b0, 1'b1, 4'd6, 1'b1, 1'b0);
      vecs[16] = mk(1'b0, 4'b0100, 1'b0, 4'd9, 4'b1101, 1'b0, 1'b1, 4'd6, 1'b0, 1'b0);
      vecs[17] = mk(1'b0, 4'b0100, 1'b0, 4'd9, 4'b1101, 1'b0, 1'b1, 4'd6, 1'b0, 1'b0);
      vecs[18] = mk(1'b0, 4'b0100, 1'b0, 4'd9, 4'b1101, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0);

      rst          = 1'b0;
      w_en         = 1'b0;
      g_rptr_async = 4'b0000;
      af_thresh    = 4'd6;
      clr_ovf      = 1'b0;

      #2;
      chk_outputs("reset_hold", 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
      tick();
      tick();
      chk_outputs("reset_edges", 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
      #2 rst = 1'b1;
      tick();
      tick();
      chk_outputs("post_reset", 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
      $display("reset b=%0d full=%0b lvl=%0d ovf=%0b", b_wptr, full, wr_level, overflow);

      for (int i = 0; i < NVEC; i++) begin
         w_en         = vecs[i].w_en;
         g_rptr_async = vecs[i].g_r;
         clr_ovf      = vecs[i].clr;
         tick();
         $display("vec %0d w_en=%0b g_r=%b clr=%0b -> b=%0d g=%b full=%0b af=%0b lvl=%0d ack=%0b ovf=%0b",
                  i, vecs[i].w_en, vecs[i].g_r, vecs[i].clr, b_wptr, g_wptr, full,
                  almost_full, wr_level, wr_ack, overflow);
         chk_outputs($sformatf("vec%0d", i), vecs[i].b, vecs[i].g, vecs[i].full, vecs[i].af,
                     vecs[i].lvl, vecs[i].ack, vecs[i].ovf);
      end
      clr_ovf = 1'b0;

      // Streaming across the 15 -> 0 rollover with the read pointer trailing by two.
      for (int i = 0; i < 20; i++) begin
         rp           = 4'(7 + i);
         w_en         = 1'b1;
         g_rptr_async = gray4(rp);
         tick();
         eb = 4'(10 + i);
         el = (i == 0) ? 4'd3 : (i == 1) ? 4'd4 : 4'd5;
         $display("wrap %0d g_r=%b -> b=%0d g=%b full=%0b lvl=%0d ack=%0b",
                  i, g_rptr_async, b_wptr, g_wptr, full, wr_level, wr_ack);
         chk_outputs($sformatf("wrap%0d", i), eb, gray4(eb), 1'b0, 1'b0, el, 1'b1, 1'b0);
         if (i == 5) chk("wrap_g15", int'(g_wptr), 8);
         if (i == 6) chk("wrap_g0", int'(g_wptr), 0);
      end

      // Refill against a frozen read pointer (binary 10) until full; expected after 5 edges at b=2.
      n    = 0;
      seen = 1'b0;
      w_en = 1'b1;
      for (int k = 0; k < 12 && !seen; k++) begin
         tick();
         n++;
         if (full) seen = 1'b1;
      end
      $display("refill edges=%0d b=%0d full=%0b lvl=%0d", n, b_wptr, full, wr_level);
      chk("refill_edges", n, 5);
      chk("refill_b", int'(b_wptr), 2);
      chk("refill_lvl", int'(wr_level), 8);
      tick();
      $display("blocked b=%0d full=%0b ack=%0b ovf=%0b", b_wptr, full, wr_ack, overflow);
      chk("blocked_b", int'(b_wptr), 2);
      chk("blocked_ack", int'(wr_ack), 0);
      chk("blocked_full", int'(full), 1);
      chk("blocked_ovf", int'(overflow), 1);

      // Asynchronous reset between edges must clear everything before the next edge.
      #2 rst = 1'b0;
      #1;
      $display("async_reset b=%0d full=%0b ovf=%0b", b_wptr, full, overflow);
      chk_outputs("async_reset", 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
      #2;
      g_rptr_async = 4'b0000;
      rst          = 1'b1;
      w_en         = 1'b1;
      chk("first_waddr", int'(waddr), 0);
      tick();
      $display("first_write b=%0d ack=%0b lvl=%0d", b_wptr, wr_ack, wr_level);
      chk_outputs("first_write", 4'd1, 4'b0001, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0);
      w_en = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
